clm_mod_p_out: RTL and testbench

CLM_MOD_P_OUT -- requirements
Module: clm_mod_p_out

---
 rtl/clm_mod_p_out_pkg.sv | 37 +++
 rtl/clm_poly_reduce_step.sv | 39 +++
 rtl/clm_mod_p_out.sv | 129 ++++++++++++
 tb/tb_clm_mod_p_out.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clm_mod_p_out_pkg.sv
// Shared types for the redundant-representation output stage.
//
// D            : default redundancy degree; each element carries 8+D bits.
// ctr_bits()   : width of a counter that must reach deg without wrapping.
// MP_CTR_BITS  : step-counter width for the default degree.
// state_t      : one redundant element, Verilog bit b = coefficient of x^b.
// state_vec_t  : 16 elements, [i][j] holds AES byte 4*i+j.
// base_poly_t  : degree-8 base polynomial, Verilog bit b = coefficient of x^b.
// mm_matrix_t  : 8x8 GF(2) basis map, row r produces output bit r.
// mp_stages_t  : operation stages of clm_mod_p_out.
//
// Descending packed ranges are used throughout. The conceptual bit i
// (coefficient of x^(W-1-i)) therefore lives at Verilog index W-1-i.
// The packed bit pattern is identical to an ascending [0:W-1] declaration.
package clm_mod_p_out_pkg;

    localparam int D = 8;

    function automatic int ctr_bits(input int deg);
        return $clog2(deg + 1);
    endfunction

    localparam int MP_CTR_BITS = ctr_bits(D);

    typedef logic [7+D:0]          state_t;
    typedef state_t [3:0][3:0]     state_vec_t;
    typedef logic [8:0]            base_poly_t;
    typedef logic [7:0][7:0]       mm_matrix_t;

    typedef enum logic [1:0] {
        MP_IDLE,
        MP_REDUCE,
        MP_MAP,
        MP_DONE
    } mp_stages_t;

endpackage

// File: rtl/clm_poly_reduce_step.sv
// One polynomial-reduction step for a single redundant element (combinational).
//
// elem_i : element before the step, bit b = coefficient of x^b
// poly_i : monic base polynomial P, bit b = coefficient of x^b
// step_i : step index k; this step clears the x^(7+d-k) term
// elem_o : element after the step
//
// When the x^(7+d-k) coefficient is set, P * x^(d-1-k) is XORed in. Its
// leading term is exactly x^(7+d-k), so for a monic P that term is cancelled.
module clm_poly_reduce_step
    import clm_mod_p_out_pkg::*;
#(
    parameter int d     = D,
    parameter int CTR_W = ctr_bits(d)
) (
    input  logic [7+d:0]     elem_i,
    input  base_poly_t       poly_i,
    input  logic [CTR_W-1:0] step_i,
    output logic [7+d:0]     elem_o
);

    localparam int EW = 8 + d;

    logic [EW-1:0] poly_top;
    logic [EW-1:0] poly_shift;
    logic [EW-1:0] lead_mask;
    logic          lead;

    // P * x^(d-1) puts the x^8 term of P on the element's top bit.
    assign poly_top   = {poly_i, {(d-1){1'b0}}};
    assign poly_shift = poly_top >> step_i;

    // A shifted one-hot mask selects the coefficient under test.
    assign lead_mask  = {1'b1, {(EW-1){1'b0}}} >> step_i;
    assign lead       = |(elem_i & lead_mask);

    assign elem_o     = lead ? (elem_i ^ poly_shift) : elem_i;

endmodule

// File: rtl/clm_mod_p_out.sv
// Final output stage: reduce 16 redundant elements mod P, then map each
// 8-bit residue through Linv to produce the 128-bit ciphertext.
//
// clk        : clock, all state updates on the rising edge
// rst        : asynchronous active-low reset
// drdy_i     : input-valid strobe, honoured only in IDLE
// in         : 16 elements of 8+d bits, in[i][j] is AES byte 4*i+j
// P          : base polynomial, bit 8 = x^8 coefficient (must be 1)
// Linv       : GF(2) basis map, row r gives output bit r (bit r = x^r)
// ciphertext : result, byte k at [127-8k -: 8] (byte 0 most significant)
// drdy_o     : one-cycle result-valid pulse in DONE
// busy       : high whenever an operation is in flight
// p_err      : latched at accept, high when P is not monic
module clm_mod_p_out
    import clm_mod_p_out_pkg::*;
#(
    parameter int d = D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  drdy_i,
    input  logic [3:0][3:0][7+d:0] in,
    input  base_poly_t            P,
    input  mm_matrix_t            Linv,
    output logic [127:0]          ciphertext,
    output logic                  drdy_o,
    output logic                  busy,
    output logic                  p_err
);

    localparam int CTR_W = ctr_bits(d);
    localparam int EW    = 8 + d;

    mp_stages_t                state_q;
    logic [CTR_W-1:0]          ctr_q;
    logic [3:0][3:0][EW-1:0]   elem_q;
    logic [3:0][3:0][EW-1:0]   elem_d;
    base_poly_t                p_q;
    mm_matrix_t                linv_q;
    logic [127:0]              mapped;
    logic [127:0]              ct_d;
    logic [127:0]              ct_q;
    logic                      drdy_q;
    logic                      busy_q;
    logic                      perr_q;

    // All 16 elements take the same reduction step each REDUCE cycle.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_elem
            clm_poly_reduce_step #(
                .d     (d),
                .CTR_W (CTR_W)
            ) u_step (
                .elem_i (elem_q[gi/4][gi%4]),
                .poly_i (p_q),
                .step_i (ctr_q),
                .elem_o (elem_d[gi/4][gi%4])
            );
        end
    endgenerate

    // Linv mapping of the residue (low 8 bits) of every element.
    // Byte k sits at [127-8k -: 8]. Its bit gb is at index 120-8k+gb.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_map
            for (genvar gb = 0; gb < 8; gb++) begin : g_bit
                assign mapped[120 - 8*gi + gb] = ^(linv_q[gb] & elem_q[gi/4][gi%4][7:0]);
            end
        end
    endgenerate

    // A non-monic P makes the residue meaningless, so the result is forced to zero.
    assign ct_d = perr_q ? '0 : mapped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MP_IDLE;
            ctr_q   <= '0;
            elem_q  <= '0;
            p_q     <= '0;
            linv_q  <= '0;
            ct_q    <= '0;
            drdy_q  <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                MP_IDLE: begin
                    if (drdy_i) begin
                        elem_q  <= in;
                        p_q     <= P;
                        linv_q  <= Linv;
                        ctr_q   <= '0;
                        perr_q  <= ~P[8];
                        busy_q  <= 1'b1;
                        state_q <= MP_REDUCE;
                    end
                end
                MP_REDUCE: begin
                    elem_q <= elem_d;
                    // Counter ends at d, which fits in CTR_W bits, so it never wraps.
                    ctr_q  <= ctr_q + 1'b1;
                    if (ctr_q == CTR_W'(d - 1)) begin
                        state_q <= MP_MAP;
                    end
                end
                MP_MAP: begin
                    ct_q    <= ct_d;
                    drdy_q  <= 1'b1;
                    state_q <= MP_DONE;
                end
                MP_DONE: begin
                    drdy_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= MP_IDLE;
                end
                default: begin
                    state_q <= MP_IDLE;
                end
            endcase
        end
    end

    assign ciphertext = ct_q;
    assign drdy_o     = drdy_q;
    assign busy       = busy_q;
    assign p_err      = perr_q;

endmodule

// File: tb/tb_clm_mod_p_out.sv
// Self-checking bench for clm_mod_p_out at d = 8.
// The reference treats each element as a GF(2) polynomial. Its residue is
// the XOR of (x^b mod P) over the set bits b. Linv is applied as a GF(2)
// matrix product using parity of popcounts.
module tb_clm_mod_p_out;
    import clm_mod_p_out_pkg::*;

    localparam int DD       = 8;
    localparam int LAT      = DD + 2;
    localparam int BB_N     = 50;
    localparam int BB_DRIVE = 40;

    typedef logic [3:0][3:0][15:0] vec_t;

    logic         clk;
    logic         rst;
    logic         drdy_i;
    vec_t         in_v;
    base_poly_t   p_v;
    mm_matrix_t   l_v;
    logic [127:0] ciphertext;
    logic         drdy_o;
    logic         busy;
    logic         p_err;

    int n_checks = 0;
    int n_pass   = 0;

    clm_mod_p_out #(.d(DD)) dut (
        .clk        (clk),
        .rst        (rst),
        .drdy_i     (drdy_i),
        .in         (in_v),
        .P          (p_v),
        .Linv       (l_v),
        .ciphertext (ciphertext),
        .drdy_o     (drdy_o),
        .busy       (busy),
        .p_err      (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[i][j] = 16'($urandom);
        return v;
    endfunction

    function automatic vec_t fill_vec(input logic [15:0] e);
        vec_t v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[i][j] = e;
        return v;
    endfunction

    function automatic mm_matrix_t rand_mat();
        mm_matrix_t m;
        for (int r = 0; r < 8; r++) m[r] = 8'($urandom);
        return m;
    endfunction

    function automatic mm_matrix_t ident_mat();
        mm_matrix_t m;
        for (int r = 0; r < 8; r++) m[r] = 8'(1) << r;
        return m;
    endfunction

    function automatic mm_matrix_t rev_mat();
        mm_matrix_t m;
        for (int r = 0; r < 8; r++) m[r] = 8'(1) << (7 - r);
        return m;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mod(input logic [15:0] e, input base_poly_t p);
        logic [7:0] pw;
        logic [7:0] r;
        pw = 8'h01;
        r  = 8'h00;
        for (int b = 0; b < 16; b++) begin
            if (e[b]) r ^= pw;
            pw = {pw[6:0], 1'b0} ^ (pw[7] ? p[7:0] : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_map(input mm_matrix_t m, input logic [7:0] red);
        logic [7:0] o;
        for (int r = 0; r < 8; r++) o[r] = ($countones(m[r] & red) % 2) == 1;
        return o;
    endfunction

    function automatic logic [127:0] ref_ct(input vec_t v, input base_poly_t p, input mm_matrix_t m);
        logic [127:0] c;
        c = '0;
        if (p[8]) begin
            for (int k = 0; k < 16; k++)
                c[127 - 8*k -: 8] = ref_map(m, ref_mod(v[k/4][k%4], p));
        end
        return c;
    endfunction

    // Drive one operation and collect what the DUT did; no checking here.
    task automatic run_op(input vec_t v, input base_poly_t p, input mm_matrix_t m,
                          output int lat, output logic [127:0] ct, output logic perr,
                          output logic busy_mid, output logic drdy_after,
                          output logic busy_after, output logic [127:0] ct_after);
        @(negedge clk);
        in_v   = v;
        p_v    = p;
        l_v    = m;
        drdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drdy_i   = 1'b0;
        busy_mid = busy;
        in_v     = rand_vec();
        p_v      = base_poly_t'($urandom);
        l_v      = rand_mat();
        lat      = -1;
        ct       = 'x;
        perr     = 1'bx;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (drdy_o === 1'b1) begin
                lat  = n + 1;
                ct   = ciphertext;
                perr = p_err;
                break;
            end
        end
        drdy_after = 1'bx;
        busy_after = 1'bx;
        ct_after   = 'x;
        if (lat > 0) begin
            @(negedge clk);
            drdy_after = drdy_o;
            busy_after = busy;
            ct_after   = ciphertext;
        end
        $display("op P=%h lat=%0d ct=%h p_err=%b", p, lat, ct, perr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b0;
        drdy_i = 1'b0;
        in_v   = rand_vec();
        p_v    = 9'h11B;
        l_v    = ident_mat();
        repeat (3) @(negedge clk);
        n_checks++; if (ciphertext !== 128'h0) $display("FAIL reset_ct: got %h need %h", ciphertext, 128'h0); else n_pass++;
        n_checks++; if (drdy_o !== 1'b0) $display("FAIL reset_drdy: got %b need 0", drdy_o); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else n_pass++;
        n_checks++; if (p_err !== 1'b0) $display("FAIL reset_perr: got %b need 0", p_err); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_strobe: busy got %b need 0", busy); else n_pass++;
        $display("reset done");
    endtask

    task automatic test_vec030();
        int lat; logic [127:0] ct, ct_after; logic perr, bm, da, ba;
        run_op(fill_vec(16'h0100), 9'b1_0001_1011, ident_mat(), lat, ct, perr, bm, da, ba, ct_after);
        n_checks++; if (lat != LAT) $display("FAIL v030_latency: got %0d need %0d", lat, LAT); else n_pass++;
        n_checks++; if (ct !== {16{8'h1B}}) $display("FAIL v030_ct: got %h need %h", ct, {16{8'h1B}}); else n_pass++;
        n_checks++; if (perr !== 1'b0) $display("FAIL v030_perr: got %b need 0", perr); else n_pass++;
        n_checks++; if (bm !== 1'b1) $display("FAIL v030_busy_mid: got %b need 1", bm); else n_pass++;
        n_checks++; if (da !== 1'b0) $display("FAIL v030_pulse_width: drdy_o got %b need 0", da); else n_pass++;
        n_checks++; if (ba !== 1'b0) $display("FAIL v030_busy_after: got %b need 0", ba); else n_pass++;
        n_checks++; if (ct_after !== {16{8'h1B}}) $display("FAIL v030_ct_hold: got %h need %h", ct_after, {16{8'h1B}}); else n_pass++;
    endtask

    task automatic test_vec031();
        int lat; logic [127:0] ct, ct_after, exp_ct; logic perr, bm, da, ba; vec_t v;
        v = fill_vec(16'h00A5);
        v[0][0] = 16'h8000;
        exp_ct = {8'h2F, {15{8'hA5}}};
        run_op(v, 9'b1_0001_1011, ident_mat(), lat, ct, perr, bm, da, ba, ct_after);
        n_checks++; if (lat != LAT) $display("FAIL v031_latency: got %0d need %0d", lat, LAT); else n_pass++;
        n_checks++; if (ct !== exp_ct) $display("FAIL v031_ct: got %h need %h", ct, exp_ct); else n_pass++;
    endtask

    task automatic test_bitrev();
        int lat; logic [127:0] ct, ct_after; logic perr, bm, da, ba;
        run_op(fill_vec(16'h0001), 9'b1_0001_1011, rev_mat(), lat, ct, perr, bm, da, ba, ct_after);
        n_checks++; if (ct !== {16{8'h80}}) $display("FAIL bitrev_ct: got %h need %h", ct, {16{8'h80}}); else n_pass++;
    endtask

    task automatic test_random();
        int lat; logic [127:0] ct, ct_after, exp_ct; logic perr, bm, da, ba;
        vec_t v; base_poly_t p; mm_matrix_t m;
        for (int t = 0; t < 1000; t++) begin
            v = rand_vec();
            p = {($urandom_range(0, 7) != 0), 8'($urandom)};
            m = rand_mat();
            exp_ct = ref_ct(v, p, m);
            run_op(v, p, m, lat, ct, perr, bm, da, ba, ct_after);
            n_checks++; if (lat != LAT) $display("FAIL rand_latency[%0d]: got %0d need %0d", t, lat, LAT); else n_pass++;
            n_checks++; if (ct !== exp_ct) $display("FAIL rand_ct[%0d]: got %h need %h", t, ct, exp_ct); else n_pass++;
            n_checks++; if (perr !== ~p[8]) $display("FAIL rand_perr[%0d]: got %b need %b", t, perr, ~p[8]); else n_pass++;
        end
    endtask

    // drdy_i held high while inputs change every cycle. One operation is
    // accepted per LAT+1 cycle window, and each result uses the accept-cycle inputs.
    task automatic test_back_to_back();
        vec_t       va [BB_N];
        base_poly_t pa [BB_N];
        mm_matrix_t la [BB_N];
        int acc_q[$];
        int next_acc;
        int idx;
        logic exp_drdy;
        logic [127:0] exp_ct;
        next_acc = 0;
        for (int c = 0; c < BB_N; c++) begin
            @(negedge clk);
            exp_drdy = 1'b0;
            if (acc_q.size() > 0 && acc_q[0] + LAT == c) begin
                exp_drdy = 1'b1;
                idx = acc_q.pop_front();
                exp_ct = ref_ct(va[idx], pa[idx], la[idx]);
                n_checks++; if (ciphertext !== exp_ct) $display("FAIL b2b_ct[%0d]: got %h need %h", c, ciphertext, exp_ct); else n_pass++;
                $display("b2b accepted@%0d result@%0d ct=%h", idx, c, ciphertext);
            end
            n_checks++; if (drdy_o !== exp_drdy) $display("FAIL b2b_drdy[%0d]: got %b need %b", c, drdy_o, exp_drdy); else n_pass++;
            va[c] = rand_vec();
            pa[c] = {1'b1, 8'($urandom)};
            la[c] = rand_mat();
            in_v   = va[c];
            p_v    = pa[c];
            l_v    = la[c];
            drdy_i = (c < BB_DRIVE);
            if (c < BB_DRIVE && c == next_acc) begin
                acc_q.push_back(c);
                next_acc = c + LAT + 1;
            end
        end
        drdy_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [127:0] ct, ct_after, exp_ct; logic perr, bm, da, ba;
        vec_t v; mm_matrix_t m; int bad;
        v = rand_vec(); m = rand_mat();
        exp_ct = ref_ct(v, 9'h11B, m);
        run_op(v, 9'h11B, m, lat, ct, perr, bm, da, ba, ct_after);
        n_checks++; if (ct !== exp_ct) $display("FAIL rmid_pre_ct: got %h need %h", ct, exp_ct); else n_pass++;
        @(negedge clk);
        in_v   = rand_vec();
        p_v    = 9'h01B;
        l_v    = rand_mat();
        drdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drdy_i = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b need 1", busy); else n_pass++;
        n_checks++; if (p_err !== 1'b1) $display("FAIL rmid_perr_before: got %b need 1", p_err); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (ciphertext !== 128'h0) $display("FAIL rmid_ct: got %h need %h", ciphertext, 128'h0); else n_pass++;
        n_checks++; if (drdy_o !== 1'b0) $display("FAIL rmid_drdy: got %b need 0", drdy_o); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b need 0", busy); else n_pass++;
        n_checks++; if (p_err !== 1'b0) $display("FAIL rmid_perr: got %b need 0", p_err); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (drdy_o !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL rmid_no_pulse: got %0d active cycles need 0", bad); else n_pass++;
        v = rand_vec(); m = rand_mat();
        exp_ct = ref_ct(v, 9'h11B, m);
        run_op(v, 9'h11B, m, lat, ct, perr, bm, da, ba, ct_after);
        n_checks++; if (lat != LAT) $display("FAIL rmid_post_latency: got %0d need %0d", lat, LAT); else n_pass++;
        n_checks++; if (ct !== exp_ct) $display("FAIL rmid_post_ct: got %h need %h", ct, exp_ct); else n_pass++;
    endtask

    task automatic test_p_err();
        int lat; logic [127:0] ct, ct_after; logic perr, bm, da, ba;
        run_op(rand_vec(), 9'b0_0001_1011, ident_mat(), lat, ct, perr, bm, da, ba, ct_after);
        n_checks++; if (perr !== 1'b1) $display("FAIL perr_flag: got %b need 1", perr); else n_pass++;
        n_checks++; if (lat != LAT) $display("FAIL perr_latency: got %0d need %0d", lat, LAT); else n_pass++;
        n_checks++; if (ct !== 128'h0) $display("FAIL perr_ct: got %h need %h", ct, 128'h0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vec030();
        test_vec031();
        test_bitrev();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_p_err();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
